// File: rtl/vec_store_serializer.sv
// vec_store_serializer: latches one WIDTH_V-bit vector plus base address and writes it to word memory,
// one WORD_W beat per cycle, lowest lane first. Define VEC_STORE_MASK_EN for per-lane mask / byte enables.
module vec_store_serializer #(
  parameter int WIDTH_V    = 128,
  parameter int BITS_INDEX = 8,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH_V-1:0]            in_data,
  input  logic [ADDR_W-1:0]             in_addr,
`ifdef VEC_STORE_MASK_EN
  input  logic [WIDTH_V/BITS_INDEX-1:0] in_mask,
  output logic [WORD_W/8-1:0]           mem_be,
`endif
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [WORD_W-1:0]             mem_wdata,
  input  logic                          mem_stall,
  output logic                          busy,
  output logic                          done
);

  // state   | meaning
  // S_IDLE  | waiting for a request, in_ready high
  // S_WRITE | presenting beats to memory, one per accepted cycle
  // S_DONE  | one-cycle done pulse, then back to idle

  localparam int BEATS   = WIDTH_V / WORD_W;
  localparam int BYTES_W = WORD_W / 8;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [WIDTH_V-1:0]  r_vec;
  logic [ADDR_W-1:0]   r_base;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;
  logic                r_done;

  logic                w_accept;
  logic                w_adv;
  logic                w_last;
  logic [BEAT_W-1:0]   w_beat_sel;
  logic [WIDTH_V-1:0]  w_vec_sel;
  logic [ADDR_W-1:0]   w_base_in;
  logic [ADDR_W-1:0]   w_base_sel;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic                w_we_sel;
  logic [WORD_W-1:0]   w_words [BEATS];

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_WRITE) || (r_state == S_DONE);
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done     = r_done;

  assign w_accept = in_valid && in_ready;
  // A beat presented with mem_we low (fully masked) moves on without waiting for memory.
  assign w_adv    = (r_state == S_WRITE) && (!r_mem_we || !mem_stall);
  assign w_last   = (r_beat == BEAT_W'(BEATS - 1));

  assign w_base_in  = in_addr & ~ADDR_W'(3);
  assign w_beat_sel = w_accept ? '0 : r_beat + BEAT_W'(1);
  assign w_vec_sel  = w_accept ? in_data : r_vec;
  assign w_base_sel = w_accept ? w_base_in : r_base;
  assign w_addr_sel = w_base_sel + (ADDR_W'(w_beat_sel) * ADDR_W'(BYTES_W));

  for (genvar g = 0; g < BEATS; g++) begin : g_word
    assign w_words[g] = w_vec_sel[g*WORD_W +: WORD_W];
  end

`ifdef VEC_STORE_MASK_EN
  localparam int LANES_PB = WORD_W / BITS_INDEX;
  localparam int BYTES_PL = BITS_INDEX / 8;

  logic [WIDTH_V/BITS_INDEX-1:0] r_mask;
  logic [WIDTH_V/BITS_INDEX-1:0] w_mask_sel;
  logic [LANES_PB-1:0]           w_lane_masks [BEATS];
  logic [LANES_PB-1:0]           w_lane_m;
  logic [BYTES_W-1:0]            w_be_sel;
  logic [BYTES_W-1:0]            r_mem_be;

  assign w_mask_sel = w_accept ? in_mask : r_mask;

  for (genvar g = 0; g < BEATS; g++) begin : g_lane_mask
    assign w_lane_masks[g] = w_mask_sel[g*LANES_PB +: LANES_PB];
  end

  assign w_lane_m = w_lane_masks[w_beat_sel];
  assign w_we_sel = |w_lane_m;

  for (genvar gb = 0; gb < BYTES_W; gb++) begin : g_be
    assign w_be_sel[gb] = w_lane_m[gb / BYTES_PL];
  end

  assign mem_be = r_mem_be;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask   <= '0;
      r_mem_be <= '0;
    end else begin
      if (w_accept) begin
        r_mask <= in_mask;
      end
      if (w_accept || (w_adv && !w_last)) begin
        r_mem_be <= w_be_sel;
      end
    end
  end
`else
  assign w_we_sel = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_WRITE;
      S_WRITE: if (w_adv && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The next beat's address and data are loaded on the same edge that accepts the current one,
  // so the memory side sees one beat per cycle with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat      <= '0;
      r_vec       <= '0;
      r_base      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_adv && w_last;
      if (w_accept) begin
        r_vec  <= in_data;
        r_base <= w_base_in;
      end
      if (w_accept || (w_adv && !w_last)) begin
        r_beat      <= w_beat_sel;
        r_mem_we    <= w_we_sel;
        r_mem_addr  <= w_addr_sel;
        r_mem_wdata <= w_words[w_beat_sel];
      end else if (w_adv) begin
        r_mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_store_serializer.sv
// Scoreboard bench for vec_store_serializer: a reference model expands each request into expected
// memory writes and a completion cycle; a negedge monitor compares every presented write.
module tb_vec_store_serializer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [31:0]  in_addr;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_stall;
  logic         busy;
  logic         done;
`ifdef VEC_STORE_MASK_EN
  logic [15:0]  in_mask;
  logic [3:0]   mem_be;
`endif

  vec_store_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
`ifdef VEC_STORE_MASK_EN
    .in_mask   (in_mask),
    .mem_be    (mem_be),
`endif
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] eff_mask(input logic [15:0] m);
`ifdef VEC_STORE_MASK_EN
    return m;
`else
    return 16'hFFFF;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required=none", mem_addr, mem_wdata);
      end else begin
        chk("wr_addr", mem_addr, sb[0].a);
        chk("wr_data", mem_wdata, sb[0].d);
`ifdef VEC_STORE_MASK_EN
        chk("wr_be", mem_be, sb[0].be);
`endif
        if (!mem_stall) void'(sb.pop_front());
      end
    end
  end

  // Called and returns at posedge+1. stall_s/stall_n force a stall window (cycles counted from
  // acceptance, first beat at cycle 1); abort_at asserts reset in that cycle.
  task automatic send(input logic [127:0] d, input logic [31:0] a, input logic [15:0] m,
                      input int stall_pct, input bit keep, input bit b2b, input int abort_at,
                      input int stall_s, input int stall_n);
    bit          stall_at[64];
    int          t;
    int          lows;
    logic [15:0] em;
    logic [3:0]  lm;
    logic [31:0] base;
    exp_t        e;

    for (int i = 0; i < 64; i++)
      stall_at[i] = (i > 0) && (i < 40) && ($urandom_range(99) < stall_pct);
    for (int i = stall_s; i < stall_s + stall_n; i++) stall_at[i] = 1'b1;

    em   = eff_mask(m);
    base = a & ~32'h3;
    t    = 1;
    for (int b = 0; b < 4; b++) begin
      lm = em[4*b +: 4];
      if (lm == 4'h0) begin
        t++;
      end else begin
        e.a  = base + 32'(4 * b);
        e.d  = d[32*b +: 32];
        e.be = lm;
        sb.push_back(e);
        while (stall_at[t]) t++;
        t++;
      end
    end

    in_valid = 1'b1;
    in_data  = d;
    in_addr  = a;
`ifdef VEC_STORE_MASK_EN
    in_mask  = m;
`endif
    lows = 0;
    forever begin
      mem_stall = 1'($urandom_range(1));
      @(negedge clk);
      if (in_ready) break;
      lows++;
      if (lows > 50) begin
        $display("FAIL accept_timeout actual=no_accept required=accept_within_50");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "accept timeout");
      end
    end
    if (b2b) chk("b2b_wait", 64'(lows), 64'd0);

    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    for (int c = 1; c <= t; c++) begin
      mem_stall = stall_at[c];
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_addr   = $urandom;
`ifdef VEC_STORE_MASK_EN
      in_mask   = 16'($urandom);
`endif
      if (c == abort_at) begin
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_mem_we", mem_we, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        in_valid  = 1'b0;
        mem_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      chk("done_timing", done, (c == t));
      chk("in_ready_low", in_ready, 1'b0);
      chk("busy_high", busy, 1'b1);
      @(posedge clk);
      #1;
    end
    mem_stall = 1'b0;
  endtask

  bit prev_keep;
  bit k;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    mem_stall = 1'b0;
`ifdef VEC_STORE_MASK_EN
    in_mask   = '0;
`endif
    #3 rst = 1'b1;
    #4;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_done", done, 1'b0);
`ifdef VEC_STORE_MASK_EN
    chk("rst_mem_be", mem_be, 4'h0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // basic vector, no stall
    send(128'h0F0E0D0C0B0A09080706050403020100, 32'h100, 16'hFFFF, 0, 0, 0, -1, 0, 0);
    // three stalled cycles on beat 1
    send(128'h0F0E0D0C0B0A09080706050403020100, 32'h100, 16'hFFFF, 0, 0, 0, -1, 2, 3);
    // address wrap with low bits ignored
    send({$urandom, $urandom, $urandom, $urandom}, 32'hFFFF_FFFA, 16'hFFFF, 0, 0, 0, -1, 0, 0);
    // back-to-back with valid held high
    send({$urandom, $urandom, $urandom, $urandom}, 32'h2000, 16'hFFFF, 0, 1, 0, -1, 0, 0);
    send({$urandom, $urandom, $urandom, $urandom}, 32'h3004, 16'hFFFF, 0, 0, 1, -1, 0, 0);
    // reset while beat 2 is presented, then a clean restart
    send({$urandom, $urandom, $urandom, $urandom}, 32'h4000, 16'hFFFF, 0, 0, 0, 3, 0, 0);
    send({$urandom, $urandom, $urandom, $urandom}, 32'h5008, 16'hFFFF, 0, 0, 0, -1, 0, 0);
`ifdef VEC_STORE_MASK_EN
    send({$urandom, $urandom, $urandom, $urandom}, 32'h6000, 16'h00F1, 0, 0, 0, -1, 0, 0);
    send({$urandom, $urandom, $urandom, $urandom}, 32'h6100, 16'h0000, 30, 0, 0, -1, 0, 0);
`endif

    prev_keep = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [15:0] rm;
      rm = 16'($urandom);
      if ($urandom_range(3) == 0) rm = rm & 16'h0F0F;
      k  = ($urandom_range(3) == 0);
      send({$urandom, $urandom, $urandom, $urandom}, $urandom, rm,
           int'($urandom_range(50)), k, prev_keep, -1, 0, 0);
      prev_keep = k;
    end
    in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("final_idle", in_ready, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
